// File: rtl/multicycle_sequencer_if.sv
// Memory-side handshake bundle for multicycle_sequencer: instruction fetch and data access.
interface multicycle_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [23:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack, instr);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack, instr);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb controller for the 24-bit datapath.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction request outstanding
// DECODE | classify ir_q
// EXEC   | ALU op or branch/jump resolution
// MEM    | data request outstanding
// WB     | register bank write-back
// ERROR  | memory timeout, left only by reset
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_sequencer_if.master         mem,
  input  logic                           start,
  input  logic                           branch_taken,
  output logic                           ir_load,
  output logic                           pc_en,
  output logic [1:0]                     pc_sel,
  output logic [5:0]                     alu_op,
  output logic                           flags_we,
  output logic                           rf_we,
  output logic [1:0]                     rf_wsel,
  output logic                           busy,
  output logic                           err,
  output logic [2:0]                     state_o,
  output logic [31:0]                    retired_cnt
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t        state;
  logic [23:0]   ir_q;
  logic [CW-1:0] tmo_cnt;

  logic [1:0] cls;
  logic [2:0] cond;
  logic       is_halt;
  logic       is_jal;
  logic       tmo_hit;
  logic       unused_ir;

  assign cls       = ir_q[23:22];
  assign cond      = ir_q[14:12];
  assign is_halt   = (cls == 2'b11) && (cond == 3'b111);
  assign is_jal    = (cls == 2'b11) && (cond == 3'b011);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign unused_ir = ^{ir_q[21:15], ir_q[11:10], ir_q[3:1]};

  // Counter defaults to zero so every entry into FETCH/MEM starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir_q    <= '0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= '0;
      case (state)
        S_IDLE:   if (start) state <= S_FETCH;
        S_FETCH: begin
          if (mem.imem_ack) begin
            ir_q  <= mem.instr;
            state <= S_DECODE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) state <= S_ERROR;
          end
        end
        S_DECODE: begin
          case (cls)
            2'b00:   state <= S_EXEC;
            2'b01:   state <= S_WB;
            2'b10:   state <= S_MEM;
            default: state <= is_halt ? S_IDLE : S_EXEC;
          endcase
        end
        S_EXEC:   state <= ((cls == 2'b00) || is_jal) ? S_WB : S_FETCH;
        S_MEM: begin
          if (mem.dmem_ack) begin
            state <= ir_q[0] ? S_FETCH : S_WB;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) state <= S_ERROR;
          end
        end
        S_WB:     state <= S_FETCH;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'b00;
    alu_op       = 6'b111111;
    flags_we     = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = 2'b00;
    case (state)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_load      = mem.imem_ack;
      end
      S_EXEC: begin
        if (cls == 2'b00) begin
          alu_op   = ir_q[9:4];
          flags_we = 1'b1;
        end else if (cls == 2'b11) begin
          pc_en  = 1'b1;
          pc_sel = ((cond == 3'b000) || branch_taken) ? 2'b10 : 2'b01;
        end
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = ir_q[0];
        if (mem.dmem_ack && ir_q[0]) begin
          pc_en  = 1'b1;
          pc_sel = 2'b01;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = cls;
        if (!is_jal) begin
          pc_en  = 1'b1;
          pc_sel = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign err     = (state == S_ERROR);
  assign state_o = state;

`ifdef SEQ_PERF_CNT_EN
  logic        retire;
  logic [31:0] retired_q;

  // Jump-and-link moves the PC in EXEC but is counted once, in WB.
  assign retire = ((state == S_DECODE) && is_halt) ||
                  ((state == S_EXEC) && (cls == 2'b11) && !is_jal) ||
                  ((state == S_MEM) && mem.dmem_ack && ir_q[0]) ||
                  (state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; the retired_cnt expectation follows SEQ_PERF_CNT_EN.
module tb_multicycle_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        branch_taken = 1'b0;
  logic        ir_load, pc_en, flags_we, rf_we, busy, err;
  logic [1:0]  pc_sel, rf_wsel;
  logic [5:0]  alu_op;
  logic [2:0]  state_o;
  logic [31:0] retired_cnt;
  int          errors = 0;
  int          checks = 0;

  multicycle_sequencer_if mem_bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_bus), .start(start), .branch_taken(branch_taken),
    .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .alu_op(alu_op), .flags_we(flags_we),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .busy(busy), .err(err), .state_o(state_o),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Leaves the DUT settled in its first FETCH cycle with all inputs idle.
  task automatic begin_run();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; branch_taken = 1'b0;
    mem_bus.imem_ack = 1'b0; mem_bus.dmem_ack = 1'b0; mem_bus.instr = '0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic fetch_instr(input logic [23:0] v);
    mem_bus.instr = v; mem_bus.imem_ack = 1'b1;
    @(negedge clk);
    mem_bus.imem_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_bus.imem_ack = 1'b0; mem_bus.dmem_ack = 1'b0; mem_bus.instr = '0;
    step(); step();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (alu_op !== 6'h3F) begin errors++; $display("FAIL reset_alu_op: got %0h expected 3f", alu_op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if ({mem_bus.imem_req, mem_bus.dmem_req, pc_en, rf_we} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {mem_bus.imem_req, mem_bus.dmem_req, pc_en, rf_we}); end
    checks++; if (retired_cnt !== 32'h0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired_cnt); end
  endtask

  task automatic test_alu();
    begin_run();
    checks++; if (state_o !== 3'd1 || mem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL alu_fetch: got state %0d req %0b expected 1 1", state_o, mem_bus.imem_req); end
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL alu_irload_noack: got %0b expected 0", ir_load); end
    mem_bus.instr = 24'h000130; mem_bus.imem_ack = 1'b1;
    #1;
    checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL alu_irload_pulse: got %0b expected 1", ir_load); end
    @(negedge clk); mem_bus.imem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd2 || ir_load !== 1'b0 || alu_op !== 6'h3F) begin errors++; $display("FAIL alu_decode: got state %0d irl %0b op %0h expected 2 0 3f", state_o, ir_load, alu_op); end
    step();
    checks++; if (state_o !== 3'd3 || alu_op !== 6'b010011) begin errors++; $display("FAIL alu_exec_op: got state %0d op %b expected 3 010011", state_o, alu_op); end
    checks++; if (flags_we !== 1'b1) begin errors++; $display("FAIL alu_exec_flags: got %0b expected 1", flags_we); end
    step();
    checks++; if (state_o !== 3'd5 || rf_we !== 1'b1 || rf_wsel !== 2'b00) begin errors++; $display("FAIL alu_wb: got state %0d we %0b wsel %b expected 5 1 00", state_o, rf_we, rf_wsel); end
    checks++; if (pc_en !== 1'b1 || pc_sel !== 2'b01 || flags_we !== 1'b0) begin errors++; $display("FAIL alu_wb_pc: got en %0b sel %b fw %0b expected 1 01 0", pc_en, pc_sel, flags_we); end
    step();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL alu_refetch: got %0d expected 1", state_o); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    logic we_seen = 1'b0;
    begin_run();
    fetch_instr(24'h800000);
    step();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL load_mem_state: got %0d expected 4", state_o); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      mem_bus.dmem_ack = (i == 3);
      #1;
      if (mem_bus.dmem_req === 1'b1) req_cycles++;
      if (mem_bus.dmem_we !== 1'b0) we_seen = 1'b1;
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL load_req_cycles: got %0d expected 4", req_cycles); end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL load_we: got %0b expected 0", we_seen); end
    @(negedge clk); mem_bus.dmem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd5 || rf_we !== 1'b1 || rf_wsel !== 2'b10) begin errors++; $display("FAIL load_wb: got state %0d we %0b wsel %b expected 5 1 10", state_o, rf_we, rf_wsel); end
    checks++; if (mem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %0b expected 0", mem_bus.dmem_req); end
  endtask

  task automatic test_store();
    begin_run();
    fetch_instr(24'h800001);
    step();
    mem_bus.dmem_ack = 1'b1;
    #1;
    checks++; if (mem_bus.dmem_req !== 1'b1 || mem_bus.dmem_we !== 1'b1) begin errors++; $display("FAIL store_req: got req %0b we %0b expected 1 1", mem_bus.dmem_req, mem_bus.dmem_we); end
    checks++; if (pc_en !== 1'b1 || pc_sel !== 2'b01) begin errors++; $display("FAIL store_pc: got en %0b sel %b expected 1 01", pc_en, pc_sel); end
    @(negedge clk); mem_bus.dmem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd1 || rf_we !== 1'b0) begin errors++; $display("FAIL store_no_wb: got state %0d we %0b expected 1 0", state_o, rf_we); end
  endtask

  task automatic test_branch(input logic [23:0] v, input logic bt, input logic [1:0] exp_sel,
                             input logic [2:0] exp_next, input string tag);
    begin_run();
    fetch_instr(v);
    step();
    branch_taken = bt;
    #1;
    checks++; if (state_o !== 3'd3 || pc_en !== 1'b1 || pc_sel !== exp_sel) begin errors++; $display("FAIL %s_exec: got state %0d en %0b sel %b expected 3 1 %b", tag, state_o, pc_en, pc_sel, exp_sel); end
    @(negedge clk); branch_taken = 1'b0; #1;
    checks++; if (state_o !== exp_next) begin errors++; $display("FAIL %s_next: got %0d expected %0d", tag, state_o, exp_next); end
  endtask

  task automatic test_jal();
    test_branch(24'hC03000, 1'b1, 2'b10, 3'd5, "jal");
    checks++; if (rf_we !== 1'b1 || rf_wsel !== 2'b11 || pc_en !== 1'b0) begin errors++; $display("FAIL jal_wb: got we %0b wsel %b en %0b expected 1 11 0", rf_we, rf_wsel, pc_en); end
    step();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL jal_refetch: got %0d expected 1", state_o); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    begin_run();
    for (int i = 0; i < 40 && state_o == 3'd1; i++) begin
      if (mem_bus.imem_req === 1'b1) req_cycles++;
      step();
    end
    checks++; if (req_cycles != 15) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected 15", req_cycles); end
    checks++; if (state_o !== 3'd6 || err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_error: got state %0d err %0b busy %0b expected 6 1 1", state_o, err, busy); end
    checks++; if (mem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL tmo_req_drop: got %0b expected 0", mem_bus.imem_req); end
    start = 1'b1; step(); start = 1'b0; step();
    checks++; if (state_o !== 3'd6 || err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got state %0d err %0b expected 6 1", state_o, err); end
  endtask

  task automatic test_timeout_edge();
    begin_run();
    repeat (14) step();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL tmo_edge_wait: got %0d expected 1", state_o); end
    fetch_instr(24'h000130);
    checks++; if (state_o !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL tmo_edge_ack: got state %0d err %0b expected 2 0", state_o, err); end
  endtask

  task automatic test_halt();
    begin_run();
    fetch_instr(24'hC07000);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL halt_decode: got %0d expected 2", state_o); end
    step();
    checks++; if (state_o !== 3'd0 || busy !== 1'b0 || mem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_idle: got state %0d busy %0b req %0b expected 0 0 0", state_o, busy, mem_bus.imem_req); end
  endtask

  task automatic test_reset_mid_mem();
    begin_run();
    fetch_instr(24'h800000);
    step();
    checks++; if (mem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %0b expected 1", mem_bus.dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_bus.dmem_req !== 1'b0 || state_o !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got req %0b state %0d busy %0b expected 0 0 0", mem_bus.dmem_req, state_o, busy); end
  endtask

  task automatic test_perf_count();
    logic [23:0] prog [5] = '{24'h000130, 24'h400000, 24'h800001, 24'hC01000, 24'hC07000};
    logic [31:0] exp_ret;
`ifdef SEQ_PERF_CNT_EN
    exp_ret = 32'd5;
`else
    exp_ret = 32'd0;
`endif
    begin_run();
    for (int n = 0; n < 5; n++) begin
      mem_bus.dmem_ack = 1'b1;
      fetch_instr(prog[n]);
      for (int k = 0; k < 10 && state_o != 3'd1 && state_o != 3'd0; k++) step();
    end
    mem_bus.dmem_ack = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL perf_end_idle: got %0d expected 0", state_o); end
    checks++; if (retired_cnt !== exp_ret) begin errors++; $display("FAIL perf_retired: got %0d expected %0d", retired_cnt, exp_ret); end
  endtask

  initial begin
    mem_bus.imem_ack = 1'b0; mem_bus.dmem_ack = 1'b0; mem_bus.instr = '0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch(24'hC01000, 1'b1, 2'b10, 3'd1, "br_taken");
    test_branch(24'hC01000, 1'b0, 2'b01, 3'd1, "br_not_taken");
    test_branch(24'hC00000, 1'b0, 2'b10, 3'd1, "jump_uncond");
    test_jal();
    test_timeout();
    test_timeout_edge();
    test_halt();
    test_reset_mid_mem();
    test_perf_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM controller for the 24-bit instruction datapath: fetch, decode, execute, memory and write-back, one instruction at a time.
- Holds an internal instruction register and drives PC, instruction/data memory request handshakes, ALU op, register-bank write and flag-write strobes.
- Instruction class is instr[23:22]: 00 ALU, 01 load-immediate, 10 memory (instr[0]: 0 load, 1 store), 11 branch/jump with condition instr[14:12].
- Sits between the memories/comparator and the datapath muxes, replacing purely combinational sequencing.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory request may stay unacknowledged before ERROR (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE; ignored when busy
instr  in  24  instruction memory read data, valid with imem_ack
imem_ack  in  1  instruction fetch complete
dmem_ack  in  1  data access complete
branch_taken  in  1  comparator result, sampled in EXEC for class 11
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (store)
ir_load  out  1  one-cycle pulse, datapath IR capture
pc_en  out  1  PC update strobe
pc_sel  out  2  PC source: 01 PC+1, 10 branch target
alu_op  out  6  ALU operation; 6'b111111 = no-op
flags_we  out  1  flag register write
rf_we  out  1  register bank write
rf_wsel  out  2  write-back source: 00 ALU, 01 immediate, 10 memory, 11 link (PC+1)
busy  out  1  high in every state except IDLE
err  out  1  sticky error flag
state_o  out  3  current state encoding
retired_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE, ir_q=0, timeout counter=0, alu_op=6'b111111, all other outputs 0.
- Reset asserted mid-operation: requests drop immediately and the FSM returns to IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6.
- Output timing: outputs are decoded combinationally from state and ir_q. ir_load is the exception (see FETCH).
- Strobe defaults: every strobe is 0 and alu_op=6'b111111 unless stated below.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 until imem_ack.
  - On ack: ir_q<=instr, ir_load=1 in the same cycle (Mealy), -> DECODE.
- DECODE: no strobes.
  - class 00 -> EXEC; 01 -> WB; 10 -> MEM.
  - class 11 with instr[14:12]=111 (halt) -> IDLE, counted as retired.
  - other class 11 -> EXEC.
- EXEC, class 00: alu_op=ir_q[9:4], flags_we=1, -> WB.
- EXEC, class 11:
  - pc_en=1, pc_sel = branch_taken ? 10 : 01.
  - Condition 000 is an unconditional jump: pc_sel=10 regardless of branch_taken.
  - Condition 011 (jump-and-link) -> WB. All others -> FETCH.
- MEM:
  - dmem_req=1 and dmem_we=ir_q[0] until dmem_ack.
  - Store on ack: pc_en=1, pc_sel=01, -> FETCH.
  - Load on ack -> WB.
- WB:
  - rf_we=1; rf_wsel = 00 for class 00, 01 for class 01, 10 for class 10, 11 for jump-and-link.
  - pc_en=1, pc_sel=01, except jump-and-link (PC already updated in EXEC).
  - -> FETCH.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle the request is high without ack.
  - Counter reaching MEM_TIMEOUT with no ack -> ERROR.
  - An ack in the same cycle as the limit wins (normal transition).
  - Counter width $clog2(MEM_TIMEOUT+1).
- Ack outside its request state is ignored.
- ERROR: err=1, busy=1, no strobes. Left only by reset; start is ignored.
- Retirement point: the cycle the PC advances, or the halt transition out of DECODE. Jump-and-link retires in WB.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: retired_cnt increments by 1 at each retirement point. It is reset to 0 and wraps 32'hFFFFFFFF -> 0.
- Undefined: the port remains and is tied to 32'h0, with no counter logic.

Test Plan:
- ALU: reset, start, instr=24'h000130, immediate acks -> ir_load pulse, EXEC alu_op=6'b010011 with flags_we=1. WB rf_we=1, rf_wsel=00, pc_en=1, pc_sel=01. Returns to FETCH after 4 cycles.
- Load/store: instr=24'h800000 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_wsel=10. instr=24'h800001 -> dmem_we=1, no WB, pc_en on ack.
- Branches: instr=24'hC01000 with branch_taken=1 -> pc_sel=10. Same with branch_taken=0 -> pc_sel=01. instr=24'hC03000 -> EXEC pc_sel=10, then WB rf_we=1, rf_wsel=11, pc_en=0.
- Timeout boundary: imem_ack withheld 15 cycles -> ERROR, err=1, start ignored. Ack on the 15th cycle -> DECODE, no error.
- Halt and reset: instr=24'hC07000 -> IDLE, busy=0. Async rst_n low mid-MEM -> dmem_req=0 immediately, state_o=0.
- Optional feature: with SEQ_PERF_CNT_EN, 5 instructions ending in halt -> retired_cnt=5. Without it -> retired_cnt=0.
